// File: rtl/dot4_pkg.sv
// dot4_pkg: shared types and constants for the dot-product multiply scheduler.
//   BIAS32 / BIAS16 : exponent biases for FP32 / FP16 operands
//   SIG_W           : packed significand width (hidden bit at sig[23])
//   SIGL_W / SIGR_W : left/right significand split fed to the multiplier
//   PROD_W          : lane product width (Q4.46)
//   lane_op_t       : one lane operand {sign, exp, sig}
//   state_t         : scheduler state
package dot4_pkg;

    localparam int BIAS32 = 127;
    localparam int BIAS16 = 15;
    localparam int EXP_W  = 8;
    localparam int SIG_W  = 25;
    localparam int SIGL_W = 12;
    localparam int SIGR_W = 13;
    localparam int PROD_W = 50;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } lane_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

endpackage

// File: rtl/dot4_mul_sched_multiply.sv
// multiply: combinational 4-lane significand/exponent multiplier.
//   en              : 1 = FP32 bias, 0 = FP16 bias
//   sign_a/sign_b   : per-lane operand signs
//   exp_a/exp_b     : per-lane biased exponents
//   sigl_*/sigr_*   : per-lane significand split, left = sig[24:13], right = sig[12:0]
//   sign_p/exp_p    : per-lane product sign and biased exponent (mod 256)
//   sig_p           : per-lane product significand, Q4.46
module multiply
    import dot4_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                           en,
    input  logic [LANES-1:0]               sign_a,
    input  logic [LANES-1:0]               sign_b,
    input  logic [LANES-1:0][EXP_W-1:0]    exp_a,
    input  logic [LANES-1:0][EXP_W-1:0]    exp_b,
    input  logic [LANES-1:0][SIGL_W-1:0]   sigl_a,
    input  logic [LANES-1:0][SIGL_W-1:0]   sigl_b,
    input  logic [LANES-1:0][SIGR_W-1:0]   sigr_a,
    input  logic [LANES-1:0][SIGR_W-1:0]   sigr_b,
    output logic [LANES-1:0]               sign_p,
    output logic [LANES-1:0][EXP_W-1:0]    exp_p,
    output logic [LANES-1:0][PROD_W-1:0]   sig_p
);

    logic [EXP_W-1:0] bias;
    assign bias = en ? EXP_W'(BIAS32) : EXP_W'(BIAS16);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [2*SIGL_W-1:0]        hh;
        logic [SIGL_W+SIGR_W-1:0]   hl;
        logic [SIGL_W+SIGR_W-1:0]   lh;
        logic [2*SIGR_W-1:0]        ll;

        assign hh = sigl_a[g] * sigl_b[g];
        assign hl = sigl_a[g] * sigr_b[g];
        assign lh = sigr_a[g] * sigl_b[g];
        assign ll = sigr_a[g] * sigr_b[g];

        // Partial products recombined at their split weights (2^26, 2^13, 2^0).
        assign sig_p[g] = ({26'd0, hh} << (2*SIGR_W))
                        + ({25'd0, hl} << SIGR_W)
                        + ({25'd0, lh} << SIGR_W)
                        + {24'd0, ll};

        assign sign_p[g] = sign_a[g] ^ sign_b[g];
        // Exponent sum wraps modulo 256; the normalizer downstream handles range.
        assign exp_p[g]  = exp_a[g] + exp_b[g] - bias;
    end

endmodule

// File: rtl/dot4_mul_sched.sv
// dot4_mul_sched: round-robin scheduler in front of the shared 4-lane multiply.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : two requesters; req_ready is a one-hot accept strobe
//   req_fp32            : per-requester mode (1 = FP32, 0 = FP16)
//   req_a/req_b         : operands, requester-major, lane 0 in LSBs, {sign,exp,sig}
//   res_valid/res_ready : result handshake toward the adder tree
//   res_id/res_fp32     : owner and mode of the held result
//   res_sign/exp/sig    : per-lane product; res_zero marks zero-forced lanes
//   busy                : scheduler not idle
//   op_count            : results accepted downstream (wraps)
module dot4_mul_sched
    import dot4_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OPW   = 34
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_fp32,
    input  logic [2*LANES*OPW-1:0]    req_a,
    input  logic [2*LANES*OPW-1:0]    req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_id,
    output logic                      res_fp32,
    output logic [LANES-1:0]          res_sign,
    output logic [LANES*EXP_W-1:0]    res_exp,
    output logic [LANES*PROD_W-1:0]   res_sig,
    output logic [LANES-1:0]          res_zero,
    output logic                      busy,
    output logic [15:0]               op_count
);

    state_t                        state_q, state_d;
    logic                          ptr_q, ptr_d;
    logic                          id_q, id_d;
    logic                          fp32_q, fp32_d;
    lane_op_t [LANES-1:0]          opa_q, opa_d;
    lane_op_t [LANES-1:0]          opb_q, opb_d;

    logic                          res_valid_q, res_valid_d;
    logic                          res_id_q, res_id_d;
    logic                          res_fp32_q, res_fp32_d;
    logic [LANES-1:0]              res_sign_q, res_sign_d;
    logic [LANES-1:0]              res_zero_q, res_zero_d;
    logic [LANES-1:0][EXP_W-1:0]   res_exp_q, res_exp_d;
    logic [LANES-1:0][PROD_W-1:0]  res_sig_q, res_sig_d;
    logic [15:0]                   op_count_q, op_count_d;

    logic                          any_req, gnt_id;
    logic                          take, cap, hs;
    logic [LANES*OPW-1:0]          sel_a, sel_b;

    // Pointer only matters when both requesters are valid.
    assign any_req = |req_valid;
    assign gnt_id  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign sel_a   = gnt_id ? req_a[LANES*OPW +: LANES*OPW] : req_a[0 +: LANES*OPW];
    assign sel_b   = gnt_id ? req_b[LANES*OPW +: LANES*OPW] : req_b[0 +: LANES*OPW];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        cap     = 1'b0;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                cap     = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    hs = 1'b1;
                    // Back-to-back: accept the next request in the handshake cycle.
                    if (any_req) begin
                        take    = 1'b1;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = {take & gnt_id, take & ~gnt_id};
    assign busy      = (state_q != IDLE);

    // ---------------- request latch ----------------
    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        fp32_d = fp32_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        if (take) begin
            ptr_d  = ~gnt_id;
            id_d   = gnt_id;
            fp32_d = req_fp32[gnt_id];
            opa_d  = sel_a;
            opb_d  = sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            id_q   <= 1'b0;
            fp32_q <= 1'b0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            fp32_q <= fp32_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
        end
    end

    // ---------------- multiplier ----------------
    logic [LANES-1:0]              m_sa, m_sb, m_sp;
    logic [LANES-1:0][EXP_W-1:0]   m_ea, m_eb, m_ep;
    logic [LANES-1:0][SIGL_W-1:0]  m_la, m_lb;
    logic [LANES-1:0][SIGR_W-1:0]  m_ra, m_rb;
    logic [LANES-1:0][PROD_W-1:0]  m_sig;

    for (genvar g = 0; g < LANES; g++) begin : g_split
        assign m_sa[g] = opa_q[g].sign;
        assign m_sb[g] = opb_q[g].sign;
        assign m_ea[g] = opa_q[g].exp;
        assign m_eb[g] = opb_q[g].exp;
        assign m_la[g] = opa_q[g].sig[SIG_W-1:SIGR_W];
        assign m_lb[g] = opb_q[g].sig[SIG_W-1:SIGR_W];
        assign m_ra[g] = opa_q[g].sig[SIGR_W-1:0];
        assign m_rb[g] = opb_q[g].sig[SIGR_W-1:0];
    end

    multiply #(.LANES(LANES)) u_mul (
        .en     (fp32_q),
        .sign_a (m_sa),
        .sign_b (m_sb),
        .exp_a  (m_ea),
        .exp_b  (m_eb),
        .sigl_a (m_la),
        .sigl_b (m_lb),
        .sigr_a (m_ra),
        .sigr_b (m_rb),
        .sign_p (m_sp),
        .exp_p  (m_ep),
        .sig_p  (m_sig)
    );

    // ---------------- result registers ----------------
    always_comb begin
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_fp32_d  = res_fp32_q;
        res_sign_d  = res_sign_q;
        res_zero_d  = res_zero_q;
        res_exp_d   = res_exp_q;
        res_sig_d   = res_sig_q;
        op_count_d  = op_count_q;
        if (hs) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + 16'd1;
        end
        if (cap) begin
            res_valid_d = 1'b1;
            res_id_d    = id_q;
            res_fp32_d  = fp32_q;
            for (int l = 0; l < LANES; l++) begin
                // A zero exponent on either side marks a zero operand; sign still follows XOR.
                res_zero_d[l] = (opa_q[l].exp == '0) || (opb_q[l].exp == '0);
                res_sign_d[l] = m_sp[l];
                res_exp_d[l]  = res_zero_d[l] ? '0 : m_ep[l];
                res_sig_d[l]  = res_zero_d[l] ? '0 : m_sig[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_fp32_q  <= 1'b0;
            res_sign_q  <= '0;
            res_zero_q  <= '0;
            res_exp_q   <= '0;
            res_sig_q   <= '0;
            op_count_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_fp32_q  <= res_fp32_d;
            res_sign_q  <= res_sign_d;
            res_zero_q  <= res_zero_d;
            res_exp_q   <= res_exp_d;
            res_sig_q   <= res_sig_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_fp32  = res_fp32_q;
    assign res_sign  = res_sign_q;
    assign res_zero  = res_zero_q;
    assign res_exp   = res_exp_q;
    assign res_sig   = res_sig_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_dot4_mul_sched.sv
// tb_dot4_mul_sched: directed bench with a result scoreboard for dot4_mul_sched.
module tb_dot4_mul_sched;
    import dot4_pkg::*;

    localparam int LANES = 4;
    localparam int OPW   = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0]               req_fp32;
    logic [2*LANES*OPW-1:0]   req_a, req_b;
    logic                     res_valid, res_ready, res_id, res_fp32, busy;
    logic [LANES-1:0]         res_sign, res_zero;
    logic [LANES*8-1:0]       res_exp;
    logic [LANES*50-1:0]      res_sig;
    logic [15:0]              op_count;

    dot4_mul_sched #(.LANES(LANES), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fp32  (req_fp32),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_fp32  (res_fp32),
        .res_sign  (res_sign),
        .res_exp   (res_exp),
        .res_sig   (res_sig),
        .res_zero  (res_zero),
        .busy      (busy),
        .op_count  (op_count)
    );

    lane_op_t opa [2][LANES];
    lane_op_t opb [2][LANES];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < LANES; l++) begin
                req_a[(r*LANES+l)*OPW +: OPW] = opa[r][l];
                req_b[(r*LANES+l)*OPW +: OPW] = opb[r][l];
            end
        end
    end

    typedef struct packed {
        logic                id;
        logic                fp32;
        logic [LANES-1:0]    sign;
        logic [LANES-1:0]    zero;
        logic [LANES*8-1:0]  exp;
        logic [LANES*50-1:0] sig;
    } exp_t;

    exp_t        sb [$];
    int          gnt_log [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic lane_op_t mk(input logic s, input logic [7:0] e, input logic [24:0] g);
        lane_op_t o;
        o.sign = s;
        o.exp  = e;
        o.sig  = g;
        return o;
    endfunction

    // Reference: full-width product straight from the 25-bit significands.
    function automatic exp_t model(input int r);
        exp_t        e;
        logic [7:0]  bias;
        logic [49:0] p;
        logic        z;
        e      = '0;
        e.id   = r[0];
        e.fp32 = req_fp32[r];
        bias   = req_fp32[r] ? 8'd127 : 8'd15;
        for (int l = 0; l < LANES; l++) begin
            z = (opa[r][l].exp == 8'd0) || (opb[r][l].exp == 8'd0);
            p = 50'(opa[r][l].sig) * 50'(opb[r][l].sig);
            e.sign[l]         = opa[r][l].sign ^ opb[r][l].sign;
            e.zero[l]         = z;
            e.sig[l*50 +: 50] = z ? 50'd0 : p;
            e.exp[l*8 +: 8]   = z ? 8'd0 : 8'(opa[r][l].exp + opb[r][l].exp - bias);
        end
        return e;
    endfunction

    // Monitor: pops/compares results, pushes expectations at each grant.
    always @(negedge clk) begin
        exp_t e;
        int   r;
        if (!rst_n) begin
            sb.delete();
            exp_cnt = 16'd0;
        end else begin
            chk("ready_not_valid", 256'(req_ready & ~req_valid), 256'd0);
            chk("ready_onehot", 256'(req_ready == 2'b11), 256'd0);
            chk("op_count", 256'(op_count), 256'(exp_cnt));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_id",   256'(res_id),   256'(e.id));
                    chk("res_fp32", 256'(res_fp32), 256'(e.fp32));
                    chk("res_sign", 256'(res_sign), 256'(e.sign));
                    chk("res_zero", 256'(res_zero), 256'(e.zero));
                    chk("res_exp",  256'(res_exp),  256'(e.exp));
                    chk("res_sig",  256'(res_sig),  256'(e.sig));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (req_ready == 2'b01 || req_ready == 2'b10) begin
                r = int'(req_ready[1]);
                sb.push_back(model(r));
                gnt_log.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int r, input lane_op_t a, input lane_op_t b);
        for (int l = 0; l < LANES; l++) begin
            opa[r][l] = a;
            opb[r][l] = b;
        end
    endtask

    task automatic rand_ops();
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < LANES; l++) begin
                opa[r][l] = mk(1'($urandom), 8'($urandom), 25'($urandom));
                opb[r][l] = mk(1'($urandom), 8'($urandom), 25'($urandom));
            end
        end
        req_fp32 = 2'($urandom);
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk(tag, 256'(res_valid), 256'd1);
    endtask

    logic [8:0]          rv;
    logic [3:0]          gv;
    logic [LANES*50-1:0] snap_sig;
    logic [LANES*8-1:0]  snap_exp;
    logic                snap_id;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b00;
        res_ready = 1'b0;
        req_fp32  = 2'b00;
        set_all(0, mk(0, 0, 0), mk(0, 0, 0));
        set_all(1, mk(0, 0, 0), mk(0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_res_valid", 256'(res_valid), 256'd0);
        chk("rst_busy",      256'(busy),      256'd0);
        chk("rst_op_count",  256'(op_count),  256'd0);
        chk("rst_req_ready", 256'(req_ready), 256'd0);
        chk("rst_res_sig",   256'(res_sig),   256'd0);
        chk("rst_res_exp",   256'(res_exp),   256'd0);
        rst_n = 1'b1;
        tick();

        // FP32 1.0 x 1.0 on all lanes from requester 0; check 2-cycle latency
        set_all(0, mk(0, 8'd127, 25'h800000), mk(0, 8'd127, 25'h800000));
        req_fp32  = 2'b01;
        req_valid = 2'b01;
        res_ready = 1'b1;
        #1;
        chk("t1_grant", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_calc_valid", 256'(res_valid), 256'd0);
        chk("t1_calc_busy",  256'(busy),      256'd1);
        tick();
        #1;
        chk("t1_lat_valid", 256'(res_valid), 256'd1);
        chk("t1_exp",  256'(res_exp), 256'({4{8'd127}}));
        chk("t1_sig",  256'(res_sig), 256'({4{50'h4000_0000_0000}}));
        chk("t1_id",   256'(res_id),   256'd0);
        chk("t1_zero", 256'(res_zero), 256'd0);
        tick();

        // FP16 lane 2: (-1.5) x 2.0, requester 0 alone while the pointer sits on 1
        set_all(0, mk(0, 8'd15, 25'h800000), mk(0, 8'd15, 25'h800000));
        opa[0][2] = mk(1, 8'd15, 25'hC00000);
        opb[0][2] = mk(0, 8'd16, 25'h800000);
        req_fp32  = 2'b00;
        req_valid = 2'b01;
        #1;
        chk("t2_grant", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b00;
        wait_res("t2_wait");
        chk("t2_exp2",  256'(res_exp[23:16]),  256'd16);
        chk("t2_sig2",  256'(res_sig[149:100]), 256'(50'h6000_0000_0000));
        chk("t2_sign",  256'(res_sign),  256'(4'b0100));
        chk("t2_fp32",  256'(res_fp32),  256'd0);
        tick();

        // Zero lane: lane 1 exp_b = 0 with nonzero sig, requester 1
        set_all(1, mk(0, 8'd130, 25'hA00000), mk(1, 8'd126, 25'h900000));
        opb[1][1] = mk(1, 8'd0, 25'h900000);
        req_fp32  = 2'b10;
        req_valid = 2'b10;
        #1;
        chk("t3_grant", 256'(req_ready), 256'(2'b10));
        tick();
        req_valid = 2'b00;
        wait_res("t3_wait");
        chk("t3_zero",  256'(res_zero),      256'(4'b0010));
        chk("t3_sig1",  256'(res_sig[99:50]), 256'd0);
        chk("t3_exp1",  256'(res_exp[15:8]),  256'd0);
        chk("t3_sign",  256'(res_sign),       256'(4'b1111));
        chk("t3_exp0",  256'(res_exp[7:0]),   256'd129);
        chk("t3_sig0",  256'(res_sig[49:0]),  256'(50'h5A00_0000_0000));
        chk("t3_id",    256'(res_id),         256'd1);
        tick();

        // Both valid continuously: grants alternate, result every other cycle
        gnt_log.delete();
        rand_ops();
        req_valid = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) req_valid = 2'b00;
            #1;
            rv[i] = res_valid;
            tick();
            rand_ops();
        end
        #1;
        chk("t4_valid_pattern", 256'(rv), 256'(9'b101010100));
        chk("t4_op_count", 256'(op_count), 256'd7);
        chk("t4_gnt_count", 256'(gnt_log.size()), 256'd4);
        gv = '0;
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) gv[i] = gnt_log[i][0];
        chk("t4_gnt_order", 256'(gv), 256'(4'b1010));

        // Stall in HOLD for 5 cycles, then release with back-to-back grant
        req_valid = 2'b11;
        res_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("t5_hold_valid", 256'(res_valid), 256'd1);
        snap_sig = res_sig;
        snap_exp = res_exp;
        snap_id  = res_id;
        for (int i = 0; i < 5; i++) begin
            chk("t5_no_ready", 256'(req_ready), 256'd0);
            chk("t5_sig_stable", 256'(res_sig), 256'(snap_sig));
            chk("t5_exp_stable", 256'(res_exp), 256'(snap_exp));
            chk("t5_id_stable",  256'(res_id),  256'(snap_id));
            tick();
            rand_ops();
            #1;
        end
        res_ready = 1'b1;
        #1;
        chk("t5_release_grant", 256'(req_ready), 256'(2'b10));
        tick();
        req_valid = 2'b00;
        #1;
        chk("t5_op_count", 256'(op_count), 256'd8);
        wait_res("t5_wait");
        tick();
        tick();

        // Reset during CALC; pointer must return to requester 0
        req_valid = 2'b01;
        #1;
        chk("t6_grant0", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 256'(res_valid), 256'd0);
        chk("t6_rst_busy",  256'(busy),      256'd0);
        chk("t6_rst_cnt",   256'(op_count),  256'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_result", 256'(res_valid), 256'd0);
        rand_ops();
        req_valid = 2'b11;
        #1;
        chk("t6_rr_reset", 256'(req_ready), 256'(2'b01));
        tick();
        req_valid = 2'b00;
        wait_res("t6_wait");
        tick();
        tick();
        chk("sb_drained", 256'(sb.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
